// File: rtl/hx8352_bus_reader.sv
// Read-side controller for the HX8352 8080-style parallel LCD bus: issues a burst of timed RD strobes
// and samples the 16-bit data bus. Optional macro HX8352_DUMMY_READ_EN adds a leading dummy read on rs_sel=1 bursts.
module hx8352_bus_reader #(
    parameter int SETUP_CYCLES   = 1,
    parameter int RD_LOW_CYCLES  = 4,
    parameter int RD_HIGH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rs_sel,
    input  logic [7:0]  read_count,
    input  logic [15:0] lcd_data_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        lcd_rd,
    output logic        lcd_wr,
    output logic        lcd_rs,
    output logic        lcd_bus_oe
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_RD_LOW  = 3'd2,
        S_RD_HIGH = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] LOW_LOAD   = 8'(RD_LOW_CYCLES - 1);
    localparam logic [7:0] HIGH_LOAD  = 8'(RD_HIGH_CYCLES - 1);

    state_t      state_r, state_s;
    logic [7:0]  cnt_r, cnt_s;
    logic [7:0]  words_r, words_s;
    logic        rs_r, rs_s;
    logic        dummy_r, dummy_s;
    logic [15:0] data_s;
    logic        valid_s;
    logic        dummy_req_s;

`ifdef HX8352_DUMMY_READ_EN
    assign dummy_req_s = rs_sel;
`else
    assign dummy_req_s = 1'b0;
`endif

    assign lcd_wr = 1'b1;

    // Next-state, phase counter, word counter and sample capture
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        words_s = words_r;
        rs_s    = rs_r;
        dummy_s = dummy_r;
        data_s  = data_out;
        valid_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    rs_s    = rs_sel;
                    words_s = read_count;
                    dummy_s = dummy_req_s;
                    cnt_s   = SETUP_LOAD;
                    if (read_count == 8'd0) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_SETUP;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SETUP: begin
                if (cnt_r == 8'd0) begin
                    state_s = S_RD_LOW;
                    cnt_s   = LOW_LOAD;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            S_RD_LOW: begin
                if (cnt_r == 8'd0) begin
                    state_s = S_RD_HIGH;
                    cnt_s   = HIGH_LOAD;
                    // The dummy sample is discarded and does not consume a word
                    if (dummy_r) begin
                        dummy_s = 1'b0;
                    end else begin
                        data_s  = lcd_data_in;
                        valid_s = 1'b1;
                        words_s = words_r - 8'd1;
                    end
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            S_RD_HIGH: begin
                if (cnt_r == 8'd0) begin
                    if (words_r != 8'd0) begin
                        state_s = S_RD_LOW;
                        cnt_s   = LOW_LOAD;
                    end else begin
                        state_s = S_DONE;
                    end
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State and registered bus/handshake outputs, decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            cnt_r      <= 8'd0;
            words_r    <= 8'd0;
            rs_r       <= 1'b1;
            dummy_r    <= 1'b0;
            data_out   <= 16'h0000;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            lcd_rd     <= 1'b1;
            lcd_rs     <= 1'b1;
            lcd_bus_oe <= 1'b1;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            words_r    <= words_s;
            rs_r       <= rs_s;
            dummy_r    <= dummy_s;
            data_out   <= data_s;
            data_valid <= valid_s;
            busy       <= (state_s != S_IDLE);
            done       <= (state_s == S_DONE);
            lcd_rd     <= (state_s != S_RD_LOW);
            lcd_rs     <= (state_s == S_IDLE) ? 1'b1 : rs_s;
            lcd_bus_oe <= (state_s == S_IDLE);
        end
    end

endmodule
